// File: rtl/tf_lut_loader.sv
// tf_lut_loader: writer side of the tanh LUT. Streams 2*2**SEG_W host words
// (points first, then slopes) onto one LUT write bus shared by every LUT copy.
// The word that follows the last data word is a 16-bit wrap-around checksum.
// lut_valid is raised only after that checksum matches.
module tf_lut_loader #(
    parameter int DATA_W = 16,
    parameter int SEG_W  = 5
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [SEG_W:0]    wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              lut_valid
);

    localparam int NUM_WORDS = 2 * (2 ** SEG_W);
    localparam logic [SEG_W:0] LAST_WORD = (SEG_W + 1)'(NUM_WORDS - 1);
    localparam logic [SEG_W:0] ONE_WORD  = (SEG_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state;
    logic [SEG_W:0]    count;
    logic [DATA_W-1:0] sum;
    logic              accept;

    // The loader only takes words while loading or waiting for the checksum;
    // an abort in the same cycle drops the offered word.
    assign in_ready = (state == ST_LOAD) || (state == ST_CHECK);
    assign busy     = in_ready;
    assign accept   = in_valid && in_ready && !abort;

    // Load sequencer: the word count doubles as the LUT address, and each
    // accepted data word is registered onto the write bus for one cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            count     <= '0;
            sum       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            lut_valid <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        lut_valid <= 1'b0;
                    end else if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= count;
                        wr_data <= in_data;
                        count   <= count + ONE_WORD;
                        sum     <= sum + in_data;
                        if (count == LAST_WORD) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        lut_valid <= 1'b0;
                    end else if (accept) begin
                        if (in_data == sum) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            lut_valid <= 1'b1;
                        end else begin
                            state     <= ST_ERR;
                            err       <= 1'b1;
                            lut_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (start) begin
                        state     <= ST_LOAD;
                        count     <= '0;
                        sum       <= '0;
                        err       <= 1'b0;
                        lut_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tf_lut_loader.sv
// tb_tf_lut_loader: table of whole-load scenarios plus hand-written abort,
// reset and start/abort corner sequences. Expected LUT contents and checksums
// come from a word array and a plain arithmetic sum in the bench.
module tb_tf_lut_loader;

    localparam int DATA_W    = 16;
    localparam int SEG_W     = 5;
    localparam int NUM_WORDS = 64;

    logic              clk = 1'b0;
    logic              clrn;
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [SEG_W:0]    wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              lut_valid;

    tf_lut_loader #(.DATA_W(DATA_W), .SEG_W(SEG_W)) dut (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err), .lut_valid(lut_valid)
    );

    always #5 clk = ~clk;

    typedef enum int {PAT_INC, PAT_ONES, PAT_RAND} pat_e;
    typedef enum int {GAP_NONE, GAP_TOGGLE, GAP_RAND} gap_e;

    typedef struct {
        string       name;
        pat_e        pat;
        gap_e        gap;
        bit          use_model;
        logic [15:0] checksum;
        logic [15:0] offset;
        bit          exp_done;
        bit          exp_err;
        bit          exp_valid;
    } vec_t;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_rec_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] words [NUM_WORDS];
    wr_rec_t     wr_log [$];
    vec_t        table_v [7];

    // Every LUT write seen on the bus, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_log.push_back('{addr: int'(wr_addr), data: wr_data});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle for gap cycles with junk on the data bus, then offer one word.
    task automatic applyStimulus(input logic [15:0] word, input int gap);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_data = 16'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = word;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] model_sum();
        int total = 0;
        for (int i = 0; i < NUM_WORDS; i++) total += int'(words[i]);
        return 16'(total % 65536);
    endfunction

    task automatic fill_words(input pat_e pat);
        for (int i = 0; i < NUM_WORDS; i++) begin
            case (pat)
                PAT_INC:  words[i] = 16'(i * 257);
                PAT_ONES: words[i] = 16'hFFFF;
                default:  words[i] = 16'($urandom);
            endcase
        end
    endtask

    function automatic int pick_gap(input gap_e gap, input int idx);
        int g;
        case (gap)
            GAP_TOGGLE: g = (idx == 31) ? 11 : 1;
            GAP_RAND:   g = int'($urandom_range(0, 3));
            default:    g = 0;
        endcase
        return g;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_log(input string name, input int n);
        checkOutput({name, "/write_count"}, 32'(wr_log.size()), 32'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            checkOutput($sformatf("%s/addr%0d", name, i), 32'(wr_log[i].addr), 32'(i));
            checkOutput($sformatf("%s/data%0d", name, i), 32'(wr_log[i].data), 32'(words[i]));
        end
    endtask

    task automatic run_load(input vec_t v);
        logic [15:0] chk;
        fill_words(v.pat);
        wr_log.delete();
        pulse_start();
        checkOutput({v.name, "/busy_after_start"}, 32'(busy), 32'd1);
        checkOutput({v.name, "/ready_after_start"}, 32'(in_ready), 32'd1);
        checkOutput({v.name, "/err_cleared"}, 32'(err), 32'd0);
        checkOutput({v.name, "/valid_cleared"}, 32'(lut_valid), 32'd0);
        for (int i = 0; i < NUM_WORDS; i++) applyStimulus(words[i], pick_gap(v.gap, i));
        checkOutput({v.name, "/busy_in_check"}, 32'(busy), 32'd1);
        checkOutput({v.name, "/no_done_early"}, 32'(done), 32'd0);
        chk = (v.use_model ? model_sum() : v.checksum) + v.offset;
        applyStimulus(chk, pick_gap(v.gap, 0));
        checkOutput({v.name, "/done"}, 32'(done), 32'(v.exp_done));
        checkOutput({v.name, "/err"}, 32'(err), 32'(v.exp_err));
        checkOutput({v.name, "/lut_valid"}, 32'(lut_valid), 32'(v.exp_valid));
        checkOutput({v.name, "/busy_end"}, 32'(busy), 32'd0);
        checkOutput({v.name, "/checksum_not_written"}, 32'(wr_en), 32'd0);
        checkOutput({v.name, "/addr_hold"}, 32'(wr_addr), 32'd63);
        checkOutput({v.name, "/data_hold"}, 32'(wr_data), 32'(words[63]));
        tick();
        checkOutput({v.name, "/done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({v.name, "/lut_valid_hold"}, 32'(lut_valid), 32'(v.exp_valid));
        checkOutput({v.name, "/err_hold"}, 32'(err), 32'(v.exp_err));
        check_log(v.name, NUM_WORDS);
    endtask

    initial begin
        #2_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        table_v[0] = '{"inc_b2b",    PAT_INC,  GAP_NONE,   1'b0, 16'hE7E0, 16'h0000, 1'b1, 1'b0, 1'b1};
        table_v[1] = '{"inc_badsum", PAT_INC,  GAP_NONE,   1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        table_v[2] = '{"ones_wrap",  PAT_ONES, GAP_NONE,   1'b0, 16'hFFC0, 16'h0000, 1'b1, 1'b0, 1'b1};
        table_v[3] = '{"inc_toggle", PAT_INC,  GAP_TOGGLE, 1'b0, 16'hE7E0, 16'h0000, 1'b1, 1'b0, 1'b1};
        table_v[4] = '{"rand_good",  PAT_RAND, GAP_RAND,   1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        table_v[5] = '{"rand_bad",   PAT_RAND, GAP_RAND,   1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0};
        table_v[6] = '{"rand_b2b",   PAT_RAND, GAP_NONE,   1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};

        clrn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) tick();
        checkOutput("reset/wr_en", 32'(wr_en), 32'd0);
        checkOutput("reset/wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset/wr_data", 32'(wr_data), 32'd0);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        checkOutput("reset/in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset/done", 32'(done), 32'd0);
        checkOutput("reset/err", 32'(err), 32'd0);
        checkOutput("reset/lut_valid", 32'(lut_valid), 32'd0);
        clrn = 1'b1;
        tick();
        checkOutput("idle/busy", 32'(busy), 32'd0);

        for (int t = 0; t < 7; t++) run_load(table_v[t]);

        // Abort after word 20, with word 21 offered in the abort cycle.
        fill_words(PAT_INC);
        wr_log.delete();
        pulse_start();
        for (int i = 0; i <= 20; i++) applyStimulus(words[i], 0);
        abort = 1'b1; in_valid = 1'b1; in_data = words[21];
        tick();
        abort = 1'b0; in_valid = 1'b0;
        checkOutput("abort/busy", 32'(busy), 32'd0);
        checkOutput("abort/in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort/lut_valid", 32'(lut_valid), 32'd0);
        checkOutput("abort/err", 32'(err), 32'd0);
        repeat (3) tick();
        applyStimulus(16'h1234, 0);
        tick();
        check_log("abort", 21);
        run_load(table_v[0]);

        // start and abort together in DONE: abort wins, nothing is accepted.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checkOutput("start_abort/busy", 32'(busy), 32'd0);
        wr_log.delete();
        applyStimulus(16'h5A5A, 0);
        tick();
        checkOutput("start_abort/no_write", 32'(wr_log.size()), 32'd0);

        // Reset after word 40, with a start pulse mid-load that must be ignored.
        fill_words(PAT_RAND);
        wr_log.delete();
        pulse_start();
        for (int i = 0; i <= 40; i++) begin
            start = (i == 10);
            applyStimulus(words[i], 0);
            start = 1'b0;
        end
        tick();
        checkOutput("midreset/busy_before", 32'(busy), 32'd1);
        #2 clrn = 1'b0;
        #1;
        checkOutput("midreset/wr_en", 32'(wr_en), 32'd0);
        checkOutput("midreset/wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("midreset/wr_data", 32'(wr_data), 32'd0);
        checkOutput("midreset/busy", 32'(busy), 32'd0);
        checkOutput("midreset/in_ready", 32'(in_ready), 32'd0);
        checkOutput("midreset/done", 32'(done), 32'd0);
        checkOutput("midreset/err", 32'(err), 32'd0);
        checkOutput("midreset/lut_valid", 32'(lut_valid), 32'd0);
        tick();
        clrn = 1'b1;
        tick();
        check_log("midreset", 41);
        run_load(table_v[4]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
